demux4_stream: RTL and testbench

Stream demultiplexer that steers one 16-bit producer stream to one of four consumer channels chosen by a 2-bit select, with valid/ready handshakes on both sides. It is the fan-out counterpart of the CPU's 4-way 16-bit result selector: it sends a single datapath source to the write-back, memory, I/O or debug sinks. Each channel has its own 2-entry FIFO, so a stalled consumer blocks only its own channel.

---
 rtl/demux4_stream.sv | 104 ++++++++++
 tb/tb_demux4_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// demux4_stream: one valid/ready producer steered to four independent channels, each with a 2-entry FIFO.
// Optional per-channel accept counters are built when DEMUX4_STATS_EN is defined.
module demux4_stream #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic             busy
`ifdef DEMUX4_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_cnt0,
  output logic [15:0]      stat_cnt1,
  output logic [15:0]      stat_cnt2,
  output logic [15:0]      stat_cnt3
`endif
);

  logic [WIDTH-1:0] mem [4][2];
  logic [1:0]       cnt [4];
  logic [3:0]       wptr;
  logic [3:0]       rptr;
  logic             push;
  logic [3:0]       push_ch;
  logic [3:0]       pop;

  // in_ready depends only on the registered count of the selected channel, never on out_ready.
  always_comb begin
    out_valid = '0;
    push_ch   = '0;
    pop       = '0;
    in_ready  = (cnt[in_sel] != 2'd2) & rst_n;
    push      = in_valid & in_ready;
    for (int unsigned n = 0; n < 4; n++) begin
      out_valid[n] = (cnt[n] != 2'd0);
      push_ch[n]   = push & (in_sel == 2'(n));
      pop[n]       = out_valid[n] & out_ready[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned n = 0; n < 4; n++) begin
        cnt[n]    <= '0;
        mem[n][0] <= '0;
        mem[n][1] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (push_ch[n]) begin
          mem[n][wptr[n]] <= in_data;
          wptr[n]         <= ~wptr[n];
        end
        if (pop[n])
          rptr[n] <= ~rptr[n];
        if (push_ch[n] != pop[n])
          cnt[n] <= push_ch[n] ? cnt[n] + 2'd1 : cnt[n] - 2'd1;
      end
    end
  end

  assign out_data0 = mem[0][rptr[0]];
  assign out_data1 = mem[1][rptr[1]];
  assign out_data2 = mem[2][rptr[2]];
  assign out_data3 = mem[3][rptr[3]];
  assign busy      = |out_valid;

`ifdef DEMUX4_STATS_EN
  logic [15:0] stat [4];

  // Clear wins over a same-edge increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < 4; n++)
        stat[n] <= '0;
    end else if (stat_clr) begin
      for (int unsigned n = 0; n < 4; n++)
        stat[n] <= '0;
    end else begin
      for (int unsigned n = 0; n < 4; n++)
        if (push_ch[n] && (stat[n] != 16'hFFFF))
          stat[n] <= stat[n] + 16'd1;
    end
  end

  assign stat_cnt0 = stat[0];
  assign stat_cnt1 = stat[1];
  assign stat_cnt2 = stat[2];
  assign stat_cnt3 = stat[3];
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed vector table, hand sequences, then random traffic against a queue model.
// Statistics checks are compiled only when DEMUX4_STATS_EN is defined.
module tb_demux4_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = '0;
  logic [15:0] in_data = '0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic        busy;
`ifdef DEMUX4_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

  demux4_stream #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .busy      (busy)
`ifdef DEMUX4_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_cnt3 (stat_cnt3)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  int unsigned nvec = 0;
  int unsigned nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [15:0] d;
    logic [3:0]  ord;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [1:0]  chk;
    logic [15:0] exp_d;
  } vec_t;

  vec_t tbl [17];

  // Reference model: one queue per channel, bounded at two words.
  logic [15:0] q [4][$];

  task automatic model_step();
    logic        v;
    logic [1:0]  s;
    logic [15:0] d;
    logic [3:0]  r;
    logic        e_rdy;
    logic [3:0]  e_ov;
    v = ($urandom_range(0, 3) != 0);
    s = 2'($urandom_range(0, 3));
    d = 16'($urandom);
    r = 4'($urandom);
    drive(v, s, d, r);
    #1;
    e_rdy = (q[s].size() < 2);
    e_ov  = '0;
    for (int n = 0; n < 4; n++) e_ov[n] = (q[n].size() != 0);
    check("rnd_in_ready", in_ready, e_rdy);
    check("rnd_out_valid", out_valid, e_ov);
    check("rnd_busy", busy, |e_ov);
    for (int n = 0; n < 4; n++)
      if (e_ov[n]) check($sformatf("rnd_data%0d", n), od[n], q[n][0]);
    @(posedge clk);
    for (int n = 0; n < 4; n++)
      if (e_ov[n] && r[n]) void'(q[n].pop_front());
    if (v && e_rdy) q[s].push_back(d);
    @(negedge clk);
  endtask

  initial begin
    // rows: {valid, sel, data, out_ready, exp in_ready, exp out_valid, channel to check, exp data}
    tbl[0]  = '{1'b1, 2'd2, 16'hA5A5, 4'hF, 1'b1, 4'b0000, 2'd2, 16'h0000};
    tbl[1]  = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0100, 2'd2, 16'hA5A5};
    tbl[2]  = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 2'd2, 16'h0000};
    tbl[3]  = '{1'b1, 2'd1, 16'h0001, 4'hD, 1'b1, 4'b0000, 2'd1, 16'h0000};
    tbl[4]  = '{1'b1, 2'd1, 16'h0002, 4'hD, 1'b1, 4'b0010, 2'd1, 16'h0001};
    tbl[5]  = '{1'b1, 2'd1, 16'h0003, 4'hD, 1'b0, 4'b0010, 2'd1, 16'h0001};
    tbl[6]  = '{1'b1, 2'd1, 16'h0003, 4'hF, 1'b0, 4'b0010, 2'd1, 16'h0001};
    tbl[7]  = '{1'b1, 2'd1, 16'h0003, 4'hF, 1'b1, 4'b0010, 2'd1, 16'h0002};
    tbl[8]  = '{1'b0, 2'd1, 16'h0000, 4'hF, 1'b1, 4'b0010, 2'd1, 16'h0003};
    tbl[9]  = '{1'b0, 2'd1, 16'h0000, 4'hF, 1'b1, 4'b0000, 2'd1, 16'h0000};
    tbl[10] = '{1'b1, 2'd0, 16'hAAAA, 4'hE, 1'b1, 4'b0000, 2'd0, 16'h0000};
    tbl[11] = '{1'b1, 2'd0, 16'hBBBB, 4'hE, 1'b1, 4'b0001, 2'd0, 16'hAAAA};
    tbl[12] = '{1'b1, 2'd3, 16'h1234, 4'hE, 1'b1, 4'b0001, 2'd0, 16'hAAAA};
    tbl[13] = '{1'b0, 2'd0, 16'h0000, 4'hE, 1'b0, 4'b1001, 2'd3, 16'h1234};
    tbl[14] = '{1'b0, 2'd3, 16'h0000, 4'hF, 1'b1, 4'b0001, 2'd0, 16'hAAAA};
    tbl[15] = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0001, 2'd0, 16'hBBBB};
    tbl[16] = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 2'd0, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 4'h0);
    check("rst_busy", busy, 1'b0);
    for (int n = 0; n < 4; n++) check($sformatf("rst_data%0d", n), od[n], 16'h0000);
    rst_n = 1'b1;
    next_cycle();
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 2'(s), 16'h0, 4'h0);
      #1;
      check($sformatf("post_rst_ready_sel%0d", s), in_ready, 1'b1);
    end
    next_cycle();

    // Directed table
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ord);
      #1;
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      check($sformatf("tbl%0d_busy", i), busy, |tbl[i].exp_ov);
      if (tbl[i].exp_ov[tbl[i].chk])
        check($sformatf("tbl%0d_data%0d", i, tbl[i].chk), od[tbl[i].chk], tbl[i].exp_d);
      next_cycle();
    end

    // Sustained push/pop at count=1 on ch2
    drive(1'b1, 2'd2, 16'h0100, 4'hF);
    next_cycle();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'd2, 16'(16'h0100 + i), 4'hF);
      #1;
      check($sformatf("pp%0d_in_ready", i), in_ready, 1'b1);
      check($sformatf("pp%0d_valid2", i), out_valid[2], 1'b1);
      check($sformatf("pp%0d_data2", i), out_data2, 16'(16'h0100 + i - 1));
      next_cycle();
    end
    drive(1'b0, 2'd2, 16'h0, 4'hF);
    #1;
    check("pp_last_data2", out_data2, 16'h0108);
    next_cycle();
    check("pp_drained", out_valid, 4'h0);

    // Reset mid-stream with every channel holding data
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 2'(n), 16'(16'hC000 + n), 4'h0);
      next_cycle();
    end
    drive(1'b1, 2'd0, 16'hDEAD, 4'h0);
    #1;
    check("mid_all_valid", out_valid, 4'hF);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 4'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    next_cycle();
    drive(1'b0, 2'd0, 16'h0, 4'hF);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1'b1);
    next_cycle();
    check("mid_rel_out_valid", out_valid, 4'h0);
    check("mid_rel_busy", busy, 1'b0);

    // Random traffic against the queue model
    for (int n = 0; n < 4; n++) q[n].delete();
    for (int i = 0; i < 2000; i++) model_step();

`ifdef DEMUX4_STATS_EN
    drive(1'b1, 2'd0, 16'h5555, 4'hF);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    @(negedge clk);
    check("stat_sat", stat_cnt0, 16'hFFFF);
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 4'hF);
    check("stat_clr_wins", stat_cnt0, 16'h0000);
    drive(1'b1, 2'd0, 16'h1, 4'hF);
    next_cycle();
    drive(1'b0, 2'd0, 16'h0, 4'hF);
    check("stat_inc", stat_cnt0, 16'h0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
